reg_check_sequencer: RTL and testbench

REG_CHECK_SEQUENCER -- requirements
Module: reg_check_sequencer

---
 rtl/reg_check_pkg.sv | 39 +++
 rtl/chk_table_ram.sv | 23 ++
 rtl/reg_check_sequencer.sv | 178 +++++++++++++++++
 tb/tb_reg_check_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_check_pkg.sv
// Shared definitions for the register check sequencer: FSM encoding and the
// packed check-table entry layout {grp, ch, expect, cycle} (cycle in the LSBs).
package reg_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The channel field carries one spare bit so that out-of-range channel
  // numbers can be written and are then reported as mismatches.
  function automatic int ch_w(input int num_ch);
    return $clog2(num_ch) + 1;
  endfunction

  function automatic int grp_w(input int num_grp);
    return (num_grp < 2) ? 1 : $clog2(num_grp);
  endfunction

  function automatic int entry_w(input int cyc_w, input int data_w,
                                 input int num_ch, input int num_grp);
    return cyc_w + data_w + ch_w(num_ch) + grp_w(num_grp);
  endfunction

  // Field offsets inside a packed entry
  function automatic int expect_lsb(input int cyc_w);
    return cyc_w;
  endfunction

  function automatic int ch_lsb(input int cyc_w, input int data_w);
    return cyc_w + data_w;
  endfunction

  function automatic int grp_lsb(input int cyc_w, input int data_w, input int num_ch);
    return cyc_w + data_w + ch_w(num_ch);
  endfunction

endpackage

// File: rtl/chk_table_ram.sv
// Check-table storage: one synchronous write port, one combinational read port.
// Contents are intentionally not reset.
module chk_table_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/reg_check_sequencer.sv
// Walks a table of {cycle, channel, expected, group} entries during a run and
// records mismatches against the live channel values, one entry per cycle.
module reg_check_sequencer
  import reg_check_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NUM_CH  = 2,
  parameter int DEPTH   = 16,
  parameter int CYC_W   = 8,
  parameter int NUM_GRP = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     num_entries,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [CYC_W-1:0]           wr_cycle,
  input  logic [ch_w(NUM_CH)-1:0]    wr_ch,
  input  logic [DATA_W-1:0]          wr_expect,
  input  logic [grp_w(NUM_GRP)-1:0]  wr_grp,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [$clog2(DEPTH):0]     fail_count,
  output logic [NUM_GRP-1:0]         grp_fail,
  output logic [$clog2(DEPTH)-1:0]   first_fail_idx,
  output logic [DATA_W-1:0]          first_fail_actual,
  output logic [1:0]                 dbg_state_o,
  output logic [CYC_W-1:0]           dbg_cyc_o,
  output logic [$clog2(DEPTH)-1:0]   dbg_idx_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int CH_W  = ch_w(NUM_CH);
  localparam int GRP_W = grp_w(NUM_GRP);
  localparam int ENT_W = entry_w(CYC_W, DATA_W, NUM_CH, NUM_GRP);

  state_e              state_q, state_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    n_q, n_d;
  logic [CNT_W-1:0]    fail_q, fail_d;
  logic [NUM_GRP-1:0]  grp_fail_q, grp_fail_d;
  logic [IDX_W-1:0]    ffi_q, ffi_d;
  logic [DATA_W-1:0]   ffa_q, ffa_d;

  logic [ENT_W-1:0]    wr_entry, rd_entry;
  logic [CYC_W-1:0]    ent_cycle;
  logic [DATA_W-1:0]   ent_exp;
  logic [CH_W-1:0]     ent_ch;
  logic [GRP_W-1:0]    ent_grp;
  logic [DATA_W-1:0]   actual;
  logic                ch_valid;
  logic [NUM_GRP-1:0]  grp_hit;
  logic                eval;
  logic                mismatch;
  logic                tbl_we;

  assign wr_entry = {wr_grp, wr_ch, wr_expect, wr_cycle};
  assign tbl_we   = wr_en && (state_q != ST_RUN) && !reset;

  chk_table_ram #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_table (
    .clk     (clk),
    .we_i    (tbl_we),
    .waddr_i (wr_addr),
    .wdata_i (wr_entry),
    .raddr_i (idx_q),
    .rdata_o (rd_entry)
  );

  assign ent_cycle = rd_entry[CYC_W-1:0];
  assign ent_exp   = rd_entry[expect_lsb(CYC_W) +: DATA_W];
  assign ent_ch    = rd_entry[ch_lsb(CYC_W, DATA_W) +: CH_W];
  assign ent_grp   = rd_entry[grp_lsb(CYC_W, DATA_W, NUM_CH) +: GRP_W];

  // Channel select; an unmatched channel number reads as zero and is invalid
  always_comb begin
    actual   = '0;
    ch_valid = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ent_ch == CH_W'(k)) begin
        actual   = ch_data[k*DATA_W +: DATA_W];
        ch_valid = 1'b1;
      end
    end
  end

  always_comb begin
    grp_hit = '0;
    for (int g = 0; g < NUM_GRP; g++) begin
      grp_hit[g] = (ent_grp == GRP_W'(g));
    end
  end

  assign eval     = (state_q == ST_RUN) && (cyc_q >= ent_cycle);
  assign mismatch = !ch_valid || (actual != ent_exp);

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    idx_d      = idx_q;
    n_d        = n_q;
    fail_d     = fail_q;
    grp_fail_d = grp_fail_q;
    ffi_d      = ffi_q;
    ffa_d      = ffa_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = (num_entries == '0) ? ST_DONE : ST_RUN;
          cyc_d      = '0;
          idx_d      = '0;
          fail_d     = '0;
          grp_fail_d = '0;
          ffi_d      = '0;
          ffa_d      = '0;
          n_d        = (num_entries > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : num_entries;
        end
      end
      ST_RUN: begin
        if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
        if (eval) begin
          idx_d = idx_q + 1'b1;
          if (mismatch) begin
            fail_d     = fail_q + 1'b1;
            grp_fail_d = grp_fail_q | grp_hit;
            if (fail_q == '0) begin
              ffi_d = idx_q;
              ffa_d = actual;
            end
          end
          if ({1'b0, idx_q} == n_q - 1'b1) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cyc_q      <= '0;
      idx_q      <= '0;
      n_q        <= '0;
      fail_q     <= '0;
      grp_fail_q <= '0;
      ffi_q      <= '0;
      ffa_q      <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      fail_q     <= fail_d;
      grp_fail_q <= grp_fail_d;
      ffi_q      <= ffi_d;
      ffa_q      <= ffa_d;
    end
  end

  assign busy              = (state_q == ST_RUN);
  assign done              = (state_q == ST_DONE);
  assign pass              = done && (fail_q == '0);
  assign fail_count        = fail_q;
  assign grp_fail          = grp_fail_q;
  assign first_fail_idx    = ffi_q;
  assign first_fail_actual = ffa_q;
  assign dbg_state_o       = state_q;
  assign dbg_cyc_o         = cyc_q;
  assign dbg_idx_o         = idx_q;

endmodule

// File: tb/tb_reg_check_sequencer.sv
// Directed bench: default instance (2 x 8-bit channels) plus a wide instance
// (4 x 16-bit channels) for channel sizing and out-of-range channel entries.
module tb_reg_check_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default instance
  logic        start;
  logic [4:0]  num_entries;
  logic [15:0] ch_data;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_cycle;
  logic [1:0]  wr_ch;
  logic [7:0]  wr_expect;
  logic [1:0]  wr_grp;
  logic        busy, done, pass;
  logic [4:0]  fail_count;
  logic [3:0]  grp_fail;
  logic [3:0]  first_fail_idx;
  logic [7:0]  first_fail_actual;
  logic [1:0]  dbg_state;
  logic [7:0]  dbg_cyc;
  logic [3:0]  dbg_idx;

  // Wide instance
  logic        w_start;
  logic [4:0]  w_num_entries;
  logic [63:0] w_ch_data;
  logic        w_wr_en;
  logic [3:0]  w_wr_addr;
  logic [7:0]  w_wr_cycle;
  logic [2:0]  w_wr_ch;
  logic [15:0] w_wr_expect;
  logic [1:0]  w_wr_grp;
  logic        w_busy, w_done, w_pass;
  logic [4:0]  w_fail_count;
  logic [3:0]  w_grp_fail;
  logic [3:0]  w_first_fail_idx;
  logic [15:0] w_first_fail_actual;
  logic [1:0]  w_dbg_state;
  logic [7:0]  w_dbg_cyc;
  logic [3:0]  w_dbg_idx;

  int n_checks = 0;
  int n_errors = 0;

  reg_check_sequencer u_dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .num_entries       (num_entries),
    .ch_data           (ch_data),
    .wr_en             (wr_en),
    .wr_addr           (wr_addr),
    .wr_cycle          (wr_cycle),
    .wr_ch             (wr_ch),
    .wr_expect         (wr_expect),
    .wr_grp            (wr_grp),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .fail_count        (fail_count),
    .grp_fail          (grp_fail),
    .first_fail_idx    (first_fail_idx),
    .first_fail_actual (first_fail_actual),
    .dbg_state_o       (dbg_state),
    .dbg_cyc_o         (dbg_cyc),
    .dbg_idx_o         (dbg_idx)
  );

  reg_check_sequencer #(
    .DATA_W (16),
    .NUM_CH (4)
  ) u_dut_w (
    .clk               (clk),
    .reset             (reset),
    .start             (w_start),
    .num_entries       (w_num_entries),
    .ch_data           (w_ch_data),
    .wr_en             (w_wr_en),
    .wr_addr           (w_wr_addr),
    .wr_cycle          (w_wr_cycle),
    .wr_ch             (w_wr_ch),
    .wr_expect         (w_wr_expect),
    .wr_grp            (w_wr_grp),
    .busy              (w_busy),
    .done              (w_done),
    .pass              (w_pass),
    .fail_count        (w_fail_count),
    .grp_fail          (w_grp_fail),
    .first_fail_idx    (w_first_fail_idx),
    .first_fail_actual (w_first_fail_actual),
    .dbg_state_o       (w_dbg_state),
    .dbg_cyc_o         (w_dbg_cyc),
    .dbg_idx_o         (w_dbg_idx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int c0, input int c1);
    ch_data = {8'(c1), 8'(c0)};
  endtask

  task automatic wr(input int addr, input int cyc, input int ch, input int exp, input int grp);
    wr_en     = 1'b1;
    wr_addr   = 4'(addr);
    wr_cycle  = 8'(cyc);
    wr_ch     = 2'(ch);
    wr_expect = 8'(exp);
    wr_grp    = 2'(grp);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic go(input int n);
    start       = 1'b1;
    num_entries = 5'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic w_wr(input int cyc, input int ch, input int exp, input int grp);
    w_wr_en     = 1'b1;
    w_wr_addr   = 4'd0;
    w_wr_cycle  = 8'(cyc);
    w_wr_ch     = 3'(ch);
    w_wr_expect = 16'(exp);
    w_wr_grp    = 2'(grp);
    tick();
    w_wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; num_entries = '0; ch_data = '0;
    wr_en = 1'b0; wr_addr = '0; wr_cycle = '0; wr_ch = '0; wr_expect = '0; wr_grp = '0;
    w_start = 1'b0; w_num_entries = '0; w_ch_data = '0;
    w_wr_en = 1'b0; w_wr_addr = '0; w_wr_cycle = '0; w_wr_ch = '0; w_wr_expect = '0; w_wr_grp = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_state", dbg_state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail_count, 0);
    chk("rst_grp", grp_fail, 0);
    chk("rst_cyc", dbg_cyc, 0);
    chk("rst_w_state", w_dbg_state, 0);

    // MOV: ch0=42 at cycle 1, ch1=123 at cycle 2
    wr(0, 1, 0, 42, 0);
    wr(1, 2, 1, 123, 0);
    go(2);
    chk("mov_busy0", busy, 1);
    chk("mov_cyc0", dbg_cyc, 0);
    drive(0, 0);   tick();
    chk("mov_idx_c1", dbg_idx, 0);
    drive(42, 0);  tick();
    chk("mov_idx_c2", dbg_idx, 1);
    drive(0, 123); tick();
    chk("mov_done", done, 1);
    chk("mov_busy", busy, 0);
    chk("mov_pass", pass, 1);
    chk("mov_fail", fail_count, 0);
    chk("mov_cyc3", dbg_cyc, 3);

    // ADD: third entry mismatches (4 vs 5), restart from DONE
    wr(0, 1, 0, 2, 1);
    wr(1, 2, 1, 3, 1);
    wr(2, 3, 0, 5, 1);
    go(3);
    drive(0, 0); tick();
    drive(2, 0); tick();
    drive(0, 3); tick();
    drive(4, 0); tick();
    chk("add_done", done, 1);
    chk("add_fail", fail_count, 1);
    chk("add_grp", grp_fail, 4'b0010);
    chk("add_ffi", first_fail_idx, 2);
    chk("add_ffa", first_fail_actual, 4);
    chk("add_pass", pass, 0);

    // Same-cycle: three entries at cycle 5, first and last mismatch
    wr(0, 5, 0, 10, 2);
    wr(1, 5, 1, 20, 3);
    wr(2, 5, 0, 30, 0);
    go(3);
    chk("sc_clr_fail", fail_count, 0);
    chk("sc_clr_grp", grp_fail, 0);
    chk("sc_clr_ffa", first_fail_actual, 0);
    drive(0, 0);
    for (int c = 0; c < 5; c++) tick();
    chk("sc_cyc5", dbg_cyc, 5);
    chk("sc_idx_c5", dbg_idx, 0);
    drive(11, 0); tick();
    chk("sc_idx_c6", dbg_idx, 1);
    drive(0, 20); tick();
    chk("sc_idx_c7", dbg_idx, 2);
    chk("sc_busy_c7", busy, 1);
    drive(31, 0); tick();
    chk("sc_done_c8", done, 1);
    chk("sc_cyc8", dbg_cyc, 8);
    chk("sc_fail", fail_count, 2);
    chk("sc_grp", grp_fail, 4'b0101);
    chk("sc_ffi", first_fail_idx, 0);
    chk("sc_ffa", first_fail_actual, 11);

    // Abort: reset at cycle 2 of a 4-entry run, with start and wr_en also high
    wr(0, 1, 0, 1, 0);
    wr(1, 2, 1, 2, 0);
    wr(2, 3, 0, 3, 0);
    wr(3, 4, 1, 4, 0);
    go(4);
    drive(0, 0); tick();
    drive(9, 9); tick();
    chk("ab_partial_fail", fail_count, 1);
    reset = 1'b1; start = 1'b1; num_entries = 5'd4;
    wr_en = 1'b1; wr_addr = 4'd0; wr_cycle = 8'd1; wr_ch = 2'd0; wr_expect = 8'd77; wr_grp = 2'd0;
    tick();
    reset = 1'b0; start = 1'b0; wr_en = 1'b0;
    chk("ab_state", dbg_state, 0);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_pass", pass, 0);
    chk("ab_fail", fail_count, 0);
    chk("ab_grp", grp_fail, 0);
    chk("ab_ffi", first_fail_idx, 0);
    chk("ab_ffa", first_fail_actual, 0);
    chk("ab_cyc", dbg_cyc, 0);
    chk("ab_idx", dbg_idx, 0);
    tick();
    chk("ab_idle_hold", dbg_state, 0);
    go(4);
    for (int c = 0; c < 4; c++) begin
      drive(c, c); tick();
    end
    chk("ab_rerun_busy", busy, 1);
    drive(4, 4); tick();
    chk("ab_rerun_done", done, 1);
    chk("ab_rerun_pass", pass, 1);

    // Edges: zero-entry start, then start/wr_en during RUN ignored
    go(0);
    chk("z_done", done, 1);
    chk("z_pass", pass, 1);
    chk("z_busy", busy, 0);
    go(2);
    drive(0, 0); tick();
    drive(1, 1);
    start = 1'b1; num_entries = 5'd0;
    wr_en = 1'b1; wr_addr = 4'd1; wr_cycle = 8'd2; wr_ch = 2'd1; wr_expect = 8'd99; wr_grp = 2'd0;
    tick();
    start = 1'b0; wr_en = 1'b0;
    chk("run_start_ign", busy, 1);
    drive(2, 2); tick();
    chk("run_wr_ign_pass", pass, 1);
    chk("run_wr_ign_fail", fail_count, 0);

    // Write in DONE takes effect
    wr(1, 2, 1, 99, 0);
    go(2);
    for (int c = 0; c < 3; c++) begin
      drive(c, c); tick();
    end
    chk("dw_done", done, 1);
    chk("dw_fail", fail_count, 1);
    chk("dw_ffi", first_fail_idx, 1);
    chk("dw_ffa", first_fail_actual, 2);
    chk("dw_pass", pass, 0);

    // Cycle counter saturation: two entries at cycle 255
    wr(0, 255, 0, 0, 0);
    wr(1, 255, 1, 0, 0);
    drive(0, 0);
    go(2);
    for (int c = 0; c < 255; c++) tick();
    chk("sat_cyc255", dbg_cyc, 255);
    chk("sat_idx0", dbg_idx, 0);
    tick();
    chk("sat_hold", dbg_cyc, 255);
    chk("sat_idx1", dbg_idx, 1);
    chk("sat_busy", busy, 1);
    tick();
    chk("sat_done", done, 1);
    chk("sat_pass", pass, 1);

    // Sizing: 4 x 16-bit channels, ch3 expecting BEEF at cycle 0
    w_wr(0, 3, 16'hBEEF, 3);
    w_ch_data = {16'hBEEF, 16'h1111, 16'h2222, 16'h3333};
    w_start = 1'b1; w_num_entries = 5'd1;
    tick();
    w_start = 1'b0;
    chk("w_busy", w_busy, 1);
    tick();
    chk("w_done", w_done, 1);
    chk("w_pass", w_pass, 1);
    chk("w_fail0", w_fail_count, 0);

    // Out-of-range channel 5 always mismatches and reports actual 0
    w_wr(0, 5, 0, 1);
    w_ch_data = '0;
    w_start = 1'b1; w_num_entries = 5'd1;
    tick();
    w_start = 1'b0;
    tick();
    chk("w_oor_done", w_done, 1);
    chk("w_oor_fail", w_fail_count, 1);
    chk("w_oor_pass", w_pass, 0);
    chk("w_oor_grp", w_grp_fail, 4'b0010);
    chk("w_oor_ffa", w_first_fail_actual, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
